ift_tagged_fifo: RTL and testbench

//  Synchronous FIFO instrumented for information-flow tracking: every data word carries a

---
 rtl/ift_pkg.sv | 13 +
 rtl/ift_sticky_taint.sv | 26 ++
 rtl/ift_tagged_fifo.sv | 109 ++++++++++
 tb/tb_ift_tagged_fifo.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ift_pkg.sv
// ift_pkg: shared definitions for information-flow-tracking blocks.
//   TAINT_W_DEF : default taint label width
//   taint_t     : taint label at default width
//   taint_or    : lattice join (bitwise OR, 0 = untainted)
package ift_pkg;
    localparam int TAINT_W_DEF = 32;

    typedef logic [TAINT_W_DEF-1:0] taint_t;

    function automatic taint_t taint_or(input taint_t a, input taint_t b);
        return a | b;
    endfunction
endpackage

// File: rtl/ift_sticky_taint.sv
// ift_sticky_taint: sticky OR-accumulating taint register, cleared only by reset.
//   clk, rst  : clock, async active-high reset
//   i_en      : accumulate i_d this cycle
//   i_d       : taint to join in
//   o_q       : current label
//   o_q_nxt   : label after this edge (lets dependants join it in the same cycle)
module ift_sticky_taint #(
    parameter int TAINT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [TAINT_W-1:0] i_d,
    output logic [TAINT_W-1:0] o_q,
    output logic [TAINT_W-1:0] o_q_nxt
);
    logic [TAINT_W-1:0] r_q;

    assign o_q_nxt = i_en ? (r_q | i_d) : r_q;
    assign o_q     = r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= o_q_nxt;
    end
endmodule

// File: rtl/ift_tagged_fifo.sv
// ift_tagged_fifo: show-ahead synchronous FIFO with taint tracking on data and control.
//   clk, rst              : clock, async active-high reset
//   push, push_t          : write request and its taint
//   wdata, wdata_t        : write data and its taint
//   pop, pop_t            : read request and its taint
//   rdata, rdata_t        : head entry and its taint
//   full/empty/count(_t)  : occupancy status; all share the occupancy taint
module ift_tagged_fifo
    import ift_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TAINT_W = TAINT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [TAINT_W-1:0]         push_t,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [TAINT_W-1:0]         wdata_t,
    input  logic                       pop,
    input  logic [TAINT_W-1:0]         pop_t,
    output logic [DATA_W-1:0]          rdata,
    output logic [TAINT_W-1:0]         rdata_t,
    output logic                       full,
    output logic [TAINT_W-1:0]         full_t,
    output logic                       empty,
    output logic [TAINT_W-1:0]         empty_t,
    output logic [$clog2(DEPTH):0]     count,
    output logic [TAINT_W-1:0]         count_t
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0]  r_mem   [DEPTH];
    logic [TAINT_W-1:0] r_mem_t [DEPTH];
    logic [AW-1:0]      r_wp, r_rp;
    logic [CW-1:0]      r_count;

    logic               w_push_ok, w_pop_ok;
    logic [TAINT_W-1:0] w_wr_t, w_wr_t_nxt, w_rd_t, w_rd_t_nxt, w_cnt_t, w_cnt_t_nxt;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;

    // A control label only matters when its request could act; a tainted
    // flag that gates a request taints the pointer it gates.
    ift_sticky_taint #(.TAINT_W(TAINT_W)) u_wr_t (
        .clk     (clk),
        .rst     (rst),
        .i_en    (push | (|push_t)),
        .i_d     ((full ? '0 : push_t) | w_cnt_t),
        .o_q     (w_wr_t),
        .o_q_nxt (w_wr_t_nxt)
    );

    ift_sticky_taint #(.TAINT_W(TAINT_W)) u_rd_t (
        .clk     (clk),
        .rst     (rst),
        .i_en    (pop | (|pop_t)),
        .i_d     ((empty ? '0 : pop_t) | w_cnt_t),
        .o_q     (w_rd_t),
        .o_q_nxt (w_rd_t_nxt)
    );

    ift_sticky_taint #(.TAINT_W(TAINT_W)) u_cnt_t (
        .clk     (clk),
        .rst     (rst),
        .i_en    (1'b1),
        .i_d     (w_wr_t_nxt | w_rd_t_nxt),
        .o_q     (w_cnt_t),
        .o_q_nxt (w_cnt_t_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i]   <= '0;
                r_mem_t[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wp]   <= wdata;
                r_mem_t[r_wp] <= wdata_t | push_t | w_wr_t;
                r_wp          <= r_wp + AW'(1);
            end
            if (w_pop_ok)
                r_rp <= r_rp + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head identity depends on both pointer histories.
    assign rdata   = r_mem[r_rp];
    assign rdata_t = r_mem_t[r_rp] | w_rd_t | w_wr_t;
    assign count   = r_count;
    assign count_t = w_cnt_t;
    assign full_t  = w_cnt_t;
    assign empty_t = w_cnt_t;
endmodule

// File: tb/tb_ift_tagged_fifo.sv
module tb_ift_tagged_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0, pop = 1'b0;
    logic [31:0] push_t = '0, wdata_t = '0, pop_t = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic [31:0] rdata_t, full_t, empty_t, count_t;
    logic        full, empty;
    logic [2:0]  count;

    int n_pass = 0;
    int n_total = 0;

    ift_tagged_fifo #(.DATA_W(8), .DEPTH(4), .TAINT_W(32)) dut (
        .clk(clk), .rst(rst),
        .push(push), .push_t(push_t), .wdata(wdata), .wdata_t(wdata_t),
        .pop(pop), .pop_t(pop_t),
        .rdata(rdata), .rdata_t(rdata_t),
        .full(full), .full_t(full_t), .empty(empty), .empty_t(empty_t),
        .count(count), .count_t(count_t)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        push;
        logic [31:0] push_t;
        logic [7:0]  wd;
        logic [31:0] wd_t;
        logic        pop;
        logic [31:0] pop_t;
        logic [7:0]  e_rd;
        logic [31:0] e_rd_t;
        logic [2:0]  e_cnt;
        logic [31:0] e_cnt_t;
        logic        e_empty;
        logic        e_full;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic ps, logic [31:0] pst, logic [7:0] wd,
                                logic [31:0] wdt, logic pp, logic [31:0] ppt,
                                logic [7:0] erd, logic [31:0] erdt, logic [2:0] ec,
                                logic [31:0] ect, logic ee, logic ef);
        vec_t v;
        v.r = r; v.push = ps; v.push_t = pst; v.wd = wd; v.wd_t = wdt;
        v.pop = pp; v.pop_t = ppt; v.e_rd = erd; v.e_rd_t = erdt; v.e_cnt = ec;
        v.e_cnt_t = ect; v.e_empty = ee; v.e_full = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [7:0] erd, input logic [31:0] erdt,
                             input logic [2:0] ec, input logic [31:0] ect,
                             input logic ee, input logic ef);
        check({tag, ".rdata"},   32'(rdata),  32'(erd));
        check({tag, ".rdata_t"}, rdata_t,     erdt);
        check({tag, ".count"},   32'(count),  32'(ec));
        check({tag, ".count_t"}, count_t,     ect);
        check({tag, ".full_t"},  full_t,      ect);
        check({tag, ".empty_t"}, empty_t,     ect);
        check({tag, ".empty"},   32'(empty),  32'(ee));
        check({tag, ".full"},    32'(full),   32'(ef));
    endtask

    task automatic idle();
        push = 0; pop = 0; push_t = '0; pop_t = '0; wdata = '0; wdata_t = '0;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] exp_head;

    initial begin
        // clean data taint
        vecs.push_back(mk(0, 1, 0, 8'hA5, 32'h1, 0, 0, 8'hA5, 32'h1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h3C, 32'h2, 0, 0, 8'hA5, 32'h1, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h3C, 32'h2, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 32'h0, 0, 0, 1, 0));
        // empty boundary: tainted pop on empty, push+pop on empty
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h10, 8'h00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h11, 0, 1, 0, 8'h11, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0));
        // full boundary
        vecs.push_back(mk(0, 1, 0, 8'h21, 0, 0, 0, 8'h21, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h22, 0, 0, 0, 8'h21, 0, 2, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h23, 0, 0, 0, 8'h21, 0, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h24, 0, 0, 0, 8'h21, 0, 4, 0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h8, 8'h99, 0, 0, 0, 8'h21, 0, 4, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h4, 8'h22, 32'h4, 3, 32'h4, 0, 0));
        // reset, then tainted push
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 32'h100, 8'h55, 0, 0, 0, 8'h55, 32'h100, 1, 32'h100, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h66, 32'h1, 0, 0, 8'h55, 32'h100, 2, 32'h100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h66, 32'h101, 1, 32'h100, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 8'h00, 32'h100, 0, 32'h100, 1, 0));

        // reset state
        #2;
        check_all("reset", 8'h00, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].r) begin
                rst = 1; #1;
                rst = 0;
            end else begin
                push = vecs[i].push; push_t = vecs[i].push_t;
                wdata = vecs[i].wd; wdata_t = vecs[i].wd_t;
                pop = vecs[i].pop; pop_t = vecs[i].pop_t;
                @(posedge clk); #1;
                idle();
            end
            check_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_rd_t, vecs[i].e_cnt,
                      vecs[i].e_cnt_t, vecs[i].e_empty, vecs[i].e_full);
        end

        // wrap: one entry in flight, 10 simultaneous push/pop pairs, clean control
        rst = 1; #1; rst = 0;
        push = 1; wdata = 8'h40; wdata_t = 32'h40;
        exp_q.push_back(8'h40);
        @(posedge clk); #1;
        for (int i = 1; i <= 10; i++) begin
            exp_head = exp_q.pop_front();
            check($sformatf("wrap%0d.rdata", i), 32'(rdata), 32'(exp_head));
            check($sformatf("wrap%0d.rdata_t", i), rdata_t, 32'(exp_head));
            push = 1; pop = 1; wdata = 8'h40 + 8'(i); wdata_t = 32'h40 + i;
            exp_q.push_back(8'h40 + 8'(i));
            @(posedge clk); #1;
            check($sformatf("wrap%0d.count", i), 32'(count), 32'd1);
        end
        idle();
        check("wrap.count_t", count_t, 0);
        check("wrap.tail", 32'(rdata), 32'h4A);

        // mid-operation async reset between edges
        push = 1; wdata = 8'h77; wdata_t = 32'h3; push_t = 32'h20;
        @(posedge clk); #1;
        idle();
        check("pre_rst.count", 32'(count), 32'd2);
        @(negedge clk);
        rst = 1; #1;
        check_all("midrst", 8'h00, 0, 0, 0, 1, 0);
        rst = 0;
        @(posedge clk); #1;
        check_all("post_rst", 8'h00, 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
